// File: rtl/pdm_cic_pkg.sv
// Shared state encoding and parameter defaults for the stereo PDM / CIC sequencer.
package pdm_cic_pkg;

   localparam int OSR_DEF   = 32;
   localparam int DW_DEF    = 12;
   localparam int DIV_W_DEF = 8;
   localparam int WARM_DEF  = 2;
   localparam int DIV_MIN   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

endpackage

// File: rtl/pdm_clkgen.sv
// PDM microphone clock divider: clamped half-period, re-sampled at every toggle,
// with one-cycle rise/fall strobes marking the toggle cycles.
module pdm_clkgen
   import pdm_cic_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             clear_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             pdm_clk_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic [DIV_W-1:0] hc_q;
   logic [DIV_W-1:0] hc_d;
   logic [DIV_W-1:0] div_eff_q;
   logic [DIV_W-1:0] div_eff_d;
   logic [DIV_W-1:0] div_cl_s;
   logic             pdm_clk_q;
   logic             pdm_clk_d;
   logic             tog_s;

   assign div_cl_s = (div_i < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_i;

   always_comb begin
      hc_d      = hc_q;
      div_eff_d = div_eff_q;
      pdm_clk_d = pdm_clk_q;
      tog_s     = 1'b0;
      if (clear_i) begin
         hc_d      = {DIV_W{1'b0}};
         pdm_clk_d = 1'b0;
         div_eff_d = div_cl_s;
      end else if (run_i) begin
         if (hc_q == div_eff_q - DIV_W'(1'b1)) begin
            // New divider value only ever applies to a whole half-period.
            tog_s     = 1'b1;
            hc_d      = {DIV_W{1'b0}};
            pdm_clk_d = ~pdm_clk_q;
            div_eff_d = div_cl_s;
         end else begin
            hc_d = hc_q + DIV_W'(1'b1);
         end
      end else begin
         hc_d      = {DIV_W{1'b0}};
         pdm_clk_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hc_q      <= {DIV_W{1'b0}};
         div_eff_q <= DIV_W'(DIV_MIN);
         pdm_clk_q <= 1'b0;
      end else begin
         hc_q      <= hc_d;
         div_eff_q <= div_eff_d;
         pdm_clk_q <= pdm_clk_d;
      end
   end

   assign rise_o    = tog_s & ~pdm_clk_q;
   assign fall_o    = tog_s &  pdm_clk_q;
   assign pdm_clk_o = pdm_clk_q;

endmodule

// File: rtl/pdm_cic_sched.sv
// Stereo PDM front-end: sequences two CIC decimators, demuxes L/R bits, discards
// warm-up frames and presents one sample pair per OSR PDM periods on valid/ready.
module pdm_cic_sched
   import pdm_cic_pkg::*;
#(
   parameter int OSR   = OSR_DEF,
   parameter int DW    = DW_DEF,
   parameter int DIV_W = DIV_W_DEF,
   parameter int WARM  = WARM_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             pdm_clk_o,
   input  logic             pdm_dat_i,
   output logic             cic_rst_o,
   output logic             cic_din_l_o,
   output logic             cic_din_r_o,
   output logic             cic_we_l_o,
   output logic             cic_we_r_o,
   input  logic [DW-1:0]    cic_out_l_i,
   input  logic [DW-1:0]    cic_out_r_i,
   output logic [DW-1:0]    smp_l_o,
   output logic [DW-1:0]    smp_r_o,
   output logic             smp_valid_o,
   input  logic             smp_ready_i,
   output logic             overrun_o,
   input  logic             clr_ovr_i
);

   localparam int BIT_W  = $clog2(OSR);
   localparam int WARM_W = $clog2(WARM + 1);

   state_e            state_q;
   state_e            state_d;
   logic              run_s;
   logic              clear_s;
   logic              rise_s;
   logic              fall_s;
   logic              last_bit_s;
   logic              capture_s;
   logic              xfer_s;
   logic              ovr_set_s;

   logic              din_l_q;
   logic              din_l_d;
   logic              din_r_q;
   logic              din_r_d;
   logic              we_l_q;
   logic              we_l_d;
   logic              we_r_q;
   logic              we_r_d;
   logic              cic_rst_q;
   logic              cic_rst_d;
   logic [BIT_W-1:0]  bit_cnt_q;
   logic [BIT_W-1:0]  bit_cnt_d;
   logic              trig_q;
   logic              trig_d;
   logic [WARM_W-1:0] warm_q;
   logic [WARM_W-1:0] warm_d;
   logic [DW-1:0]     smp_l_q;
   logic [DW-1:0]     smp_l_d;
   logic [DW-1:0]     smp_r_q;
   logic [DW-1:0]     smp_r_d;
   logic              valid_q;
   logic              valid_d;
   logic              ovr_q;
   logic              ovr_d;

   // Dropping en stops the clock and strobes in the same cycle it is seen.
   assign run_s      = (state_q == ST_RUN) && en_i;
   assign clear_s    = (state_q == ST_FLUSH);
   assign last_bit_s = (bit_cnt_q == BIT_W'(OSR - 1));
   assign xfer_s     = valid_q & smp_ready_i;

   pdm_clkgen #(
      .DIV_W (DIV_W)
   ) u_clkgen (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .run_i     (run_s),
      .clear_i   (clear_s),
      .div_i     (div_i),
      .pdm_clk_o (pdm_clk_o),
      .rise_o    (rise_s),
      .fall_o    (fall_s)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               state_d = ST_FLUSH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      din_l_d   = din_l_q;
      din_r_d   = din_r_q;
      we_l_d    = rise_s;
      we_r_d    = fall_s;
      cic_rst_d = (state_d != ST_RUN);
      if (rise_s) begin
         din_l_d = pdm_dat_i;
      end else begin
         din_l_d = din_l_q;
      end
      if (fall_s) begin
         din_r_d = pdm_dat_i;
      end else begin
         din_r_d = din_r_q;
      end
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      warm_d    = warm_q;
      trig_d    = 1'b0;
      capture_s = 1'b0;
      if (clear_s) begin
         bit_cnt_d = {BIT_W{1'b0}};
         warm_d    = {WARM_W{1'b0}};
      end else begin
         if (we_r_q) begin
            // Both CIC outputs are settled the cycle after the last right write.
            trig_d = last_bit_s;
            if (last_bit_s) begin
               bit_cnt_d = {BIT_W{1'b0}};
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_W'(1'b1);
            end
         end else begin
            bit_cnt_d = bit_cnt_q;
         end
         if (trig_q) begin
            if (warm_q < WARM_W'(WARM)) begin
               warm_d = warm_q + WARM_W'(1'b1);
            end else begin
               capture_s = 1'b1;
            end
         end else begin
            warm_d = warm_q;
         end
      end
   end

   always_comb begin
      smp_l_d   = smp_l_q;
      smp_r_d   = smp_r_q;
      valid_d   = valid_q;
      ovr_set_s = 1'b0;
      if (capture_s) begin
         if (valid_q && !smp_ready_i) begin
            ovr_set_s = 1'b1;
            valid_d   = 1'b1;
         end else begin
            smp_l_d = cic_out_l_i;
            smp_r_d = cic_out_r_i;
            valid_d = 1'b1;
         end
      end else if (xfer_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      if (ovr_set_s) begin
         ovr_d = 1'b1;
      end else if (clr_ovr_i) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         din_l_q   <= 1'b0;
         din_r_q   <= 1'b0;
         we_l_q    <= 1'b0;
         we_r_q    <= 1'b0;
         cic_rst_q <= 1'b1;
         bit_cnt_q <= {BIT_W{1'b0}};
         trig_q    <= 1'b0;
         warm_q    <= {WARM_W{1'b0}};
         smp_l_q   <= {DW{1'b0}};
         smp_r_q   <= {DW{1'b0}};
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         din_l_q   <= din_l_d;
         din_r_q   <= din_r_d;
         we_l_q    <= we_l_d;
         we_r_q    <= we_r_d;
         cic_rst_q <= cic_rst_d;
         bit_cnt_q <= bit_cnt_d;
         trig_q    <= trig_d;
         warm_q    <= warm_d;
         smp_l_q   <= smp_l_d;
         smp_r_q   <= smp_r_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end

   assign cic_rst_o   = cic_rst_q;
   assign cic_din_l_o = din_l_q;
   assign cic_din_r_o = din_r_q;
   assign cic_we_l_o  = we_l_q;
   assign cic_we_r_o  = we_r_q;
   assign smp_l_o     = smp_l_q;
   assign smp_r_o     = smp_r_q;
   assign smp_valid_o = valid_q;
   assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_pdm_cic_sched.sv
// Directed bench for pdm_cic_sched with a behavioural 2-stage OSR-32 CIC pair on its outputs.
module tb_pdm_cic_sched;

   logic        clk;
   logic        rst;
   logic        en;
   logic [7:0]  div;
   logic        pdm_clk;
   logic        pdm_dat;
   logic        cic_rst;
   logic        din_l;
   logic        din_r;
   logic        we_l;
   logic        we_r;
   logic [11:0] cic_l;
   logic [11:0] cic_r;
   logic [11:0] smp_l;
   logic [11:0] smp_r;
   logic        smp_valid;
   logic        smp_ready;
   logic        overrun;
   logic        clr_ovr;

   logic        alt_mode;
   logic        dat_val;
   int          n_vec;
   int          n_miss;
   int          cyc;

   pdm_cic_sched dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .div_i       (div),
      .pdm_clk_o   (pdm_clk),
      .pdm_dat_i   (pdm_dat),
      .cic_rst_o   (cic_rst),
      .cic_din_l_o (din_l),
      .cic_din_r_o (din_r),
      .cic_we_l_o  (we_l),
      .cic_we_r_o  (we_r),
      .cic_out_l_i (cic_l),
      .cic_out_r_i (cic_r),
      .smp_l_o     (smp_l),
      .smp_r_o     (smp_r),
      .smp_valid_o (smp_valid),
      .smp_ready_i (smp_ready),
      .overrun_o   (overrun),
      .clr_ovr_i   (clr_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Alternating mode puts 1 on the line while pdm_clk is low (left) and 0 while high (right).
   assign pdm_dat = alt_mode ? ~pdm_clk : dat_val;

   // Behavioural CIC pair: bit 1 -> +1, bit 0 -> -1, two integrators, two combs, decimate by 32.
   int          i1_q [2];
   int          i2_q [2];
   int          d1_q [2];
   int          d2_q [2];
   int          n_q  [2];
   int          i1_d [2];
   int          i2_d [2];
   int          c1_d [2];
   int          c2_d [2];
   logic [11:0] co_q [2];
   logic [1:0]  we_s;
   logic [1:0]  bit_s;

   assign we_s  = {we_r, we_l};
   assign bit_s = {din_r, din_l};
   assign cic_l = co_q[0];
   assign cic_r = co_q[1];

   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         i1_d[ch] = i1_q[ch] + (bit_s[ch] ? 1 : -1);
         i2_d[ch] = i2_q[ch] + i1_d[ch];
         c1_d[ch] = i2_d[ch] - d1_q[ch];
         c2_d[ch] = c1_d[ch] - d2_q[ch];
      end
   end

   always @(posedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (cic_rst) begin
            i1_q[ch] <= 0;
            i2_q[ch] <= 0;
            d1_q[ch] <= 0;
            d2_q[ch] <= 0;
            n_q[ch]  <= 0;
            co_q[ch] <= 12'd0;
         end else if (we_s[ch]) begin
            i1_q[ch] <= i1_d[ch];
            i2_q[ch] <= i2_d[ch];
            if (n_q[ch] == 31) begin
               n_q[ch]  <= 0;
               d1_q[ch] <= i2_d[ch];
               d2_q[ch] <= c1_d[ch];
               co_q[ch] <= c2_d[ch][11:0];
            end else begin
               n_q[ch] <= n_q[ch] + 1;
            end
         end
      end
   end

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_miss++;
         $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, want, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      cyc += n;
   endtask

   task automatic step_to(input int t);
      if (t > cyc) step(t - cyc);
   endtask

   task automatic go_idle();
      en = 1'b0;
      step(3);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of RUN cycle 0.
   task automatic start_run();
      en = 1'b1;
      @(negedge clk);
      check_vec("flush_cic_rst", 32'(cic_rst), 32'd1);
      @(negedge clk);
      cyc = 0;
      check_vec("run0_cic_rst", 32'(cic_rst), 32'd0);
      check_vec("run0_pdm_clk", 32'(pdm_clk), 32'd0);
   endtask

   task automatic wait_valid(output int at);
      while (smp_valid !== 1'b1 && cyc < 2000) step(1);
      at = (smp_valid === 1'b1) ? cyc : -1;
   endtask

   initial begin
      int e_clk;
      int e_wel;
      int e_wer;
      int e_rst;
      int e_both;
      int at;
      logic want_b;

      n_vec     = 0;
      n_miss    = 0;
      cyc       = 0;
      rst       = 1'b1;
      en        = 1'b0;
      div       = 8'd4;
      alt_mode  = 1'b0;
      dat_val   = 1'b0;
      smp_ready = 1'b1;
      clr_ovr   = 1'b0;

      // Reset and idle
      repeat (2) @(negedge clk);
      check_vec("rst_pdm_clk", 32'(pdm_clk), 32'd0);
      check_vec("rst_cic_rst", 32'(cic_rst), 32'd1);
      check_vec("rst_valid", 32'(smp_valid), 32'd0);
      check_vec("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      e_clk = 0;
      for (int c = 0; c < 100; c++) begin
         if (pdm_clk !== 1'b0 || we_l !== 1'b0 || we_r !== 1'b0 || cic_rst !== 1'b1) e_clk++;
         step(1);
      end
      check_vec("idle_quiet_errs", 32'(e_clk), 32'd0);

      // Clock and strobe timing, div=4
      start_run();
      e_clk = 0; e_wel = 0; e_wer = 0; e_rst = 0; e_both = 0;
      for (int c = 0; c < 64; c++) begin
         want_b = ((c / 4) % 2) == 1;
         if (pdm_clk !== want_b) e_clk++;
         if (we_l !== ((c % 8) == 4)) e_wel++;
         if (we_r !== ((c % 8) == 0 && c > 0)) e_wer++;
         if (cic_rst !== 1'b0) e_rst++;
         if (we_l === 1'b1 && we_r === 1'b1) e_both++;
         step(1);
      end
      check_vec("d4_pdm_clk_errs", 32'(e_clk), 32'd0);
      check_vec("d4_we_l_errs", 32'(e_wel), 32'd0);
      check_vec("d4_we_r_errs", 32'(e_wer), 32'd0);
      check_vec("d4_cic_rst_errs", 32'(e_rst), 32'd0);
      check_vec("d4_we_coincide", 32'(e_both), 32'd0);
      go_idle();

      // Divider clamp: div=1 behaves as 2
      div = 8'd1;
      start_run();
      e_clk = 0;
      for (int c = 0; c < 32; c++) begin
         want_b = ((c / 2) % 2) == 1;
         if (pdm_clk !== want_b) e_clk++;
         step(1);
      end
      check_vec("d1_clamp_errs", 32'(e_clk), 32'd0);
      go_idle();

      // Divider change 4 -> 6 mid-run, picked up at the toggle in cycle 11
      div = 8'd4;
      start_run();
      e_clk = 0;
      for (int c = 0; c < 36; c++) begin
         want_b = (c < 12) ? (((c / 4) % 2) == 1) : ((((c - 12) / 6) % 2) == 0);
         if (pdm_clk !== want_b) e_clk++;
         if (c == 10) div = 8'd6;
         step(1);
      end
      check_vec("d4to6_errs", 32'(e_clk), 32'd0);
      go_idle();
      div = 8'd4;

      // Constant ones
      dat_val = 1'b1;
      start_run();
      wait_valid(at);
      check_vec("ones_first_valid_cyc", 32'(at), 32'd770);
      check_vec("ones_smp_l", 32'(smp_l), 32'h0000_0400);
      check_vec("ones_smp_r", 32'(smp_r), 32'h0000_0400);
      check_vec("ones_din_l", 32'(din_l), 32'd1);
      go_idle();

      // Constant zeros
      dat_val = 1'b0;
      start_run();
      wait_valid(at);
      check_vec("zeros_first_valid_cyc", 32'(at), 32'd770);
      check_vec("zeros_smp_l", 32'(smp_l), 32'h0000_0C00);
      check_vec("zeros_smp_r", 32'(smp_r), 32'h0000_0C00);
      go_idle();

      // Alternating L=1 / R=0
      alt_mode = 1'b1;
      start_run();
      wait_valid(at);
      check_vec("alt_first_valid_cyc", 32'(at), 32'd770);
      check_vec("alt_smp_l", 32'(smp_l), 32'h0000_0400);
      check_vec("alt_smp_r", 32'(smp_r), 32'h0000_0C00);
      check_vec("alt_din_l", 32'(din_l), 32'd1);
      check_vec("alt_din_r", 32'(din_r), 32'd0);
      go_idle();
      alt_mode = 1'b0;

      // Backpressure: frame 3 = +1024 held; frames 5 and 6 of all-zero input = -1024
      dat_val   = 1'b1;
      smp_ready = 1'b0;
      start_run();
      step_to(770);
      check_vec("bp_valid_770", 32'(smp_valid), 32'd1);
      check_vec("bp_smp_l_770", 32'(smp_l), 32'h0000_0400);
      dat_val = 1'b0;
      step_to(1025);
      check_vec("bp_ovr_1025", 32'(overrun), 32'd0);
      step_to(1026);
      check_vec("bp_ovr_1026", 32'(overrun), 32'd1);
      check_vec("bp_held_l_1026", 32'(smp_l), 32'h0000_0400);
      check_vec("bp_valid_1026", 32'(smp_valid), 32'd1);
      step_to(1281);
      clr_ovr = 1'b1;
      step(1);
      clr_ovr = 1'b0;
      check_vec("bp_set_wins_ovr", 32'(overrun), 32'd1);
      check_vec("bp_held_l_1282", 32'(smp_l), 32'h0000_0400);
      clr_ovr = 1'b1;
      step(1);
      clr_ovr = 1'b0;
      check_vec("bp_clr_ovr", 32'(overrun), 32'd0);
      step_to(1537);
      smp_ready = 1'b1;
      step(1);
      check_vec("bp_swap_valid", 32'(smp_valid), 32'd1);
      check_vec("bp_swap_smp_l", 32'(smp_l), 32'h0000_0C00);
      check_vec("bp_swap_smp_r", 32'(smp_r), 32'h0000_0C00);
      check_vec("bp_swap_ovr", 32'(overrun), 32'd0);
      step(1);
      check_vec("bp_valid_drop", 32'(smp_valid), 32'd0);
      go_idle();

      // Disable at bit 17, then re-enable
      dat_val = 1'b1;
      start_run();
      step_to(140);
      check_vec("dis_pdm_clk_140", 32'(pdm_clk), 32'd1);
      en = 1'b0;
      step(1);
      check_vec("dis_pdm_clk_141", 32'(pdm_clk), 32'd0);
      check_vec("dis_cic_rst_141", 32'(cic_rst), 32'd1);
      e_clk = 0;
      for (int c = 0; c < 20; c++) begin
         if (pdm_clk !== 1'b0 || we_l !== 1'b0 || we_r !== 1'b0) e_clk++;
         step(1);
      end
      check_vec("dis_quiet_errs", 32'(e_clk), 32'd0);
      start_run();
      wait_valid(at);
      check_vec("reen_first_valid_cyc", 32'(at), 32'd770);
      check_vec("reen_smp_l", 32'(smp_l), 32'h0000_0400);

      // Synchronous reset mid-run
      step_to(780);
      check_vec("prerst_pdm_clk", 32'(pdm_clk), 32'd1);
      rst = 1'b1;
      en  = 1'b0;
      step(1);
      check_vec("midrst_pdm_clk", 32'(pdm_clk), 32'd0);
      check_vec("midrst_cic_rst", 32'(cic_rst), 32'd1);
      check_vec("midrst_we_l", 32'(we_l), 32'd0);
      check_vec("midrst_din_l", 32'(din_l), 32'd0);
      check_vec("midrst_smp_l", 32'(smp_l), 32'd0);
      check_vec("midrst_valid", 32'(smp_valid), 32'd0);
      check_vec("midrst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pdm_cic_sched.md
Name: pdm_cic_sched

Overview:
Stereo PDM front-end controller that sequences two instances of the team's 2-stage CIC demodulator (12-bit signed output, OSR 32).
- Generates the PDM microphone clock from the system clock and demultiplexes the shared PDM data line into left (rising-edge) and right (falling-edge) bit streams.
- Issues one-cycle write strobes and reset to each CIC, discards warm-up frames, and captures one decimated L/R sample pair per 32 PDM periods.
- Sits between the mic pads and the downstream beamforming/FIFO logic, which consumes the samples over a valid/ready handshake.

Parameters:
- OSR, 32, PDM clock periods per output sample; must match the CIC decimation.
- DW, 12, CIC output / sample width.
- DIV_W, 8, width of the divider configuration input.
- WARM, 2, decimated frames discarded after start; 2 covers CIC fill.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run enable; level.
- div  in  DIV_W  PDM clock half-period in clk cycles; values <2 are treated as 2.
- pdm_clk  out  1  clock to microphones.
- pdm_dat  in  1  shared PDM data line, already synchronised.
- cic_rst  out  1  reset to both CIC instances.
- cic_din_l  out  1  held left bit to the left CIC.
- cic_din_r  out  1  held right bit to the right CIC.
- cic_we_l  out  1  one-cycle write strobe, left CIC.
- cic_we_r  out  1  one-cycle write strobe, right CIC.
- cic_out_l  in  DW  left CIC output (signed).
- cic_out_r  in  DW  right CIC output (signed).
- smp_l  out  DW  captured left sample.
- smp_r  out  DW  captured right sample.
- smp_valid  out  1  sample pair available.
- smp_ready  in  1  consumer accepts the pair.
- overrun  out  1  sticky: a sample pair was dropped.
- clr_ovr  in  1  clears overrun.

Behaviour:
- Reset: all outputs 0 except cic_rst=1. State=IDLE; counters, hc and frame/warm counters = 0.
- IDLE:
  - pdm_clk=0, no strobes, cic_rst=1.
  - en=1 -> FLUSH.
- FLUSH:
  - Exactly one cycle; cic_rst=1; divider and counters cleared.
  - Next cycle -> RUN.
- RUN:
  - cic_rst=0.
  - The RUN entry cycle is cycle 0; at entry pdm_clk=0 and hc=0.
  - hc increments each cycle. At hc==div_eff-1: pdm_clk toggles and hc<=0.
  - div is sampled at each toggle, so changes take effect at the next half-period.
- Rising toggle cycle:
  - pdm_dat is registered into cic_din_l.
  - cic_we_l=1 in the following cycle.
- Falling toggle cycle:
  - pdm_dat is registered into cic_din_r.
  - cic_we_r=1 in the following cycle.
- Strobe/data timing:
  - we_l and we_r are never asserted in the same cycle.
  - cic_din_* hold their value until the next sample of the same channel.
- Bit counter:
  - 0..OSR-1, incremented on each cic_we_r; wraps to 0.
- Frame capture:
  - Trigger: the cycle after the cic_we_r with bit counter == OSR-1, i.e. when the CIC outputs are valid.
  - If warm counter < WARM: warm counter increments and nothing is captured.
  - Otherwise: cic_out_l/r are captured into smp_l/r and smp_valid=1 from the next cycle.
- Handshake:
  - A transfer occurs when smp_valid && smp_ready; smp_valid then drops unless a capture happens in the same cycle.
  - Capture while smp_valid && !smp_ready: the new pair is dropped, the old pair is held, and overrun<=1.
  - Capture and transfer in the same cycle: the new pair is loaded, smp_valid stays 1, no overrun.
- Overrun clear: clr_ovr clears overrun. If clr_ovr coincides with a set event, the set wins.
- en deassert in RUN:
  - Next cycle -> IDLE; pdm_clk forced 0 and strobes suppressed.
  - A pending smp_valid pair remains until it is transferred.
  - Re-enable goes through FLUSH and repeats the WARM discard.
- rst mid-operation overrides everything within one cycle.
- Timing with div_eff=D:
  - Rise toggles occur at cycles k*2D + D-1; fall toggles at (k+1)*2D-1.
  - The first valid pair is asserted at cycle (WARM+1)*OSR*2D + 2.

Decomposition:
- Package pdm_cic_pkg: state enum {IDLE, FLUSH, RUN}, OSR, DW, WARM defaults, DIV_MIN=2.
- Sub-module pdm_clkgen: half-period counter with div clamp and sampling, pdm_clk register, and rise/fall one-cycle strobe outputs, gated by run.
- The top level holds the FSM, data demux, bit/warm counters, output register and overrun logic.

Test Plan:
- Reset/idle: rst=1 two cycles, en=0 -> pdm_clk=0, cic_rst=1, smp_valid=0, overrun=0, no we strobes for 100 cycles.
- Clock/strobe timing: en=1, div=4 -> one cic_rst pulse, then pdm_clk period 8 cycles with first rise at RUN cycle 3. cic_we_l one cycle after each rise, cic_we_r one cycle after each fall; never coincident.
- Div clamp and change: div=1 -> half-period 2 cycles. Change div 4->6 mid-run -> the new 12-cycle period starts at the next toggle with no glitch.
- Constant input with real CIC instances: pdm_dat=1, div=4, smp_ready=1.
  - First smp_valid at RUN cycle 770 with smp_l=smp_r=1024.
  - pdm_dat=0 -> -1024.
  - Alternating L=1/R=0 -> smp_l=1024, smp_r=-1024.
- Backpressure: smp_ready=0 across two captures -> the first pair is held and overrun=1. clr_ovr together with a new overrun -> overrun stays 1. Ready and capture in the same cycle -> no overrun, valid stays high.
- Disable/re-enable mid-frame: en=0 at bit 17 -> IDLE next cycle, pdm_clk=0. en=1 -> FLUSH, and the first new pair arrives 770 cycles after RUN re-entry. rst mid-RUN -> all outputs at reset values the next cycle.
